// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer with one FIFO per output.
// Optional DEMUX_CNT_EN adds saturating 16-bit pop counters cnt1/cnt2.
module demux1to2_stream #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sel,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out2_data,
   output logic             out2_valid,
   input  logic             out2_ready
`ifdef DEMUX_CNT_EN
   ,
   output logic [15:0]      cnt1,
   output logic [15:0]      cnt2
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(DEPTH + 1);
   localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

   // Channel 0 feeds out1 (sel=1), channel 1 feeds out2 (sel=0).
   logic [WIDTH-1:0] mem [2][DEPTH];
   logic [AW-1:0]    wr_ptr [2];
   logic [AW-1:0]    rd_ptr [2];
   logic [OW-1:0]    occ    [2];
   logic             full   [2];
   logic             empty  [2];
   logic             push   [2];
   logic             pop    [2];
   logic             rdy_q;

   // Holds in_ready low during reset and until the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         full[c]  = (occ[c] == OCC_FULL);
         empty[c] = (occ[c] == '0);
      end
   end

   // No bypass: a full FIFO stays not-ready even if it pops this cycle.
   assign in_ready = rdy_q && (sel ? !full[0] : !full[1]);

   always_comb begin
      push[0] = in_valid && in_ready && sel;
      push[1] = in_valid && in_ready && !sel;
      pop[0]  = !empty[0] && out1_ready;
      pop[1]  = !empty[1] && out2_ready;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            occ[c]    <= '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
            if (pop[c])  rd_ptr[c] <= rd_ptr[c] + AW'(1);
            case ({push[c], pop[c]})
               2'b10:   occ[c] <= occ[c] + OW'(1);
               2'b01:   occ[c] <= occ[c] - OW'(1);
               default: occ[c] <= occ[c];
            endcase
         end
      end
   end

   // NOTE: storage is deliberately not reset; occupancy gates its visibility,
   // so stale entries are never presented and the array maps to plain RAM.
   always_ff @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (push[c]) mem[c][wr_ptr[c]] <= in_data;
      end
   end

   assign out1_valid = !empty[0];
   assign out2_valid = !empty[1];
   assign out1_data  = empty[0] ? '0 : mem[0][rd_ptr[0]];
   assign out2_data  = empty[1] ? '0 : mem[1][rd_ptr[1]];

`ifdef DEMUX_CNT_EN
   logic [15:0] cnt_q [2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (pop[c] && cnt_q[c] != 16'hFFFF) cnt_q[c] <= cnt_q[c] + 16'd1;
         end
      end
   end

   assign cnt1 = cnt_q[0];
   assign cnt2 = cnt_q[1];
`endif

endmodule
